// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Register-invalidation scoreboard for the ID stage. It holds one
//             countdown counter per architectural register. The counter gives
//             the number of cycles until that register's pending result can
//             be forwarded. Source-query ports report hazards to the stall
//             unit.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   clock
//    reset            in   synchronous active-high reset
//    stall            in   hold all counters, ignore issues
//    flush            in   clear all counters (beats stall and issues)
//    regwrite_en      in   [NISS]       issue port p writes a register
//    regwrite_adr     in   [NISS*ADRW]  destination of port p
//    regwrite_lat     in   [NISS*CNTW]  latency loaded for port p
//    src_valid        in   [NSRC]       query s in use
//    src_adr          in   [NSRC*ADRW]  query s address
//    register_invalid out  [NREG*CNTW]  counter of register r
//    reg_busy         out  [NREG]       counter r non-zero
//    src_hazard       out  [NSRC]       query s hits a busy register
//    stall_req        out               OR of src_hazard
// ============================================================================
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int ADRW = 3,
  parameter int CNTW = 3,
  parameter int NISS = 2,
  parameter int NSRC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [NISS-1:0]      regwrite_en,
  input  logic [NISS*ADRW-1:0] regwrite_adr,
  input  logic [NISS*CNTW-1:0] regwrite_lat,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC*ADRW-1:0] src_adr,
  output logic [NREG*CNTW-1:0] register_invalid,
  output logic [NREG-1:0]      reg_busy,
  output logic [NSRC-1:0]      src_hazard,
  output logic                 stall_req
);

  logic [CNTW-1:0] cnt_q     [NREG];
  logic [CNTW-1:0] cnt_d     [NREG];
  logic            issue_hit [NREG];
  logic [CNTW-1:0] issue_lat [NREG];

  // Issue decode. Ports are scanned from lowest to highest, so the
  // highest-numbered (youngest) port that targets a register wins.
  // Addresses at or above NREG never equal any r in range, so they are
  // dropped without a separate range check.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      issue_hit[r] = 1'b0;
      issue_lat[r] = '0;
      for (int p = 0; p < NISS; p++) begin
        if (regwrite_en[p] && (regwrite_adr[p*ADRW +: ADRW] == ADRW'(r))) begin
          issue_hit[r] = 1'b1;
          issue_lat[r] = regwrite_lat[p*CNTW +: CNTW];
        end
      end
    end
  end

  // Next state. A freshly loaded latency is not decremented in its load
  // cycle. Idle counters saturate at zero.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (!stall) begin
        if (issue_hit[r]) begin
          cnt_d[r] = issue_lat[r];
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  generate
    for (genvar r = 0; r < NREG; r++) begin : g_reg_out
      assign register_invalid[r*CNTW +: CNTW] = cnt_q[r];
      assign reg_busy[r]                      = |cnt_q[r];
    end
  endgenerate

  // Queries see only the registered state, with no bypass from the current
  // cycle's issues. An out-of-range address matches no register and so
  // reports no hazard.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      src_hazard[s] = 1'b0;
      if (src_valid[s]) begin
        for (int r = 0; r < NREG; r++) begin
          if ((src_adr[s*ADRW +: ADRW] == ADRW'(r)) && reg_busy[r]) begin
            src_hazard[s] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_req = |src_hazard;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard
//  Purpose  : Self-checking bench for reg_scoreboard. It uses directed
//             sequences plus random traffic against an array-based reference
//             model. Expected outputs are queued by the driver and compared
//             by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

  localparam int NREG = 8;
  localparam int ADRW = 3;
  localparam int CNTW = 3;
  localparam int NISS = 2;
  localparam int NSRC = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 stall;
  logic                 flush;
  logic [NISS-1:0]      regwrite_en;
  logic [NISS*ADRW-1:0] regwrite_adr;
  logic [NISS*CNTW-1:0] regwrite_lat;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC*ADRW-1:0] src_adr;
  logic [NREG*CNTW-1:0] register_invalid;
  logic [NREG-1:0]      reg_busy;
  logic [NSRC-1:0]      src_hazard;
  logic                 stall_req;

  always #5 clk = ~clk;

  reg_scoreboard #(
    .NREG(NREG), .ADRW(ADRW), .CNTW(CNTW), .NISS(NISS), .NSRC(NSRC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .regwrite_en      (regwrite_en),
    .regwrite_adr     (regwrite_adr),
    .regwrite_lat     (regwrite_lat),
    .src_valid        (src_valid),
    .src_adr          (src_adr),
    .register_invalid (register_invalid),
    .reg_busy         (reg_busy),
    .src_hazard       (src_hazard),
    .stall_req        (stall_req)
  );

  typedef struct {
    logic [NREG*CNTW-1:0] inv;
    logic [NREG-1:0]      busy;
    logic [NSRC-1:0]      haz;
    logic                 stl;
    int                   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt [NREG];
  bit   model_known = 1'b0;
  int   cyc_no = 0;
  int   total = 0;
  int   bad = 0;

  // One clock of stimulus. Inputs are driven at the falling edge. The
  // expected outputs for the current state and queries are then queued, and
  // the model moves on to the state that follows the next rising edge.
  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic [NISS-1:0] en,
                      input logic [NISS*ADRW-1:0] adr,
                      input logic [NISS*CNTW-1:0] lat,
                      input logic [NSRC-1:0] sv,
                      input logic [NSRC*ADRW-1:0] sa);
    exp_t e;
    int   nxt [NREG];
    int   a;
    @(negedge clk);
    reset = rst; stall = st; flush = fl;
    regwrite_en = en; regwrite_adr = adr; regwrite_lat = lat;
    src_valid = sv; src_adr = sa;
    cyc_no++;
    if (model_known) begin
      e.inv = '0; e.busy = '0; e.haz = '0; e.cyc = cyc_no;
      for (int r = 0; r < NREG; r++) begin
        e.inv[r*CNTW +: CNTW] = CNTW'(model_cnt[r]);
        e.busy[r] = (model_cnt[r] != 0);
      end
      for (int s = 0; s < NSRC; s++) begin
        a = int'(sa[s*ADRW +: ADRW]);
        e.haz[s] = sv[s] && (a < NREG) && (model_cnt[a] != 0);
      end
      e.stl = |e.haz;
      exp_q.push_back(e);
    end
    if (rst || fl) begin
      for (int r = 0; r < NREG; r++) model_cnt[r] = 0;
      model_known = 1'b1;
    end else if (!st) begin
      for (int r = 0; r < NREG; r++) nxt[r] = (model_cnt[r] > 0) ? model_cnt[r] - 1 : 0;
      for (int p = 0; p < NISS; p++) begin
        a = int'(adr[p*ADRW +: ADRW]);
        if (en[p] && a < NREG) nxt[a] = int'(lat[p*CNTW +: CNTW]);
      end
      for (int r = 0; r < NREG; r++) model_cnt[r] = nxt[r];
    end
  endtask

  // A step with no control and no issues. Queries watch registers qa and qb.
  task automatic idle(input logic [ADRW-1:0] qa, input logic [ADRW-1:0] qb);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b11, {qb, qa});
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (register_invalid !== e.inv) begin
          bad++;
          $display("FAIL register_invalid cyc=%0d got=%h exp=%h", e.cyc, register_invalid, e.inv);
        end
        total++;
        if (reg_busy !== e.busy) begin
          bad++;
          $display("FAIL reg_busy cyc=%0d got=%b exp=%b", e.cyc, reg_busy, e.busy);
        end
        total++;
        if (src_hazard !== e.haz) begin
          bad++;
          $display("FAIL src_hazard cyc=%0d got=%b exp=%b", e.cyc, src_hazard, e.haz);
        end
        total++;
        if (stall_req !== e.stl) begin
          bad++;
          $display("FAIL stall_req cyc=%0d got=%b exp=%b", e.cyc, stall_req, e.stl);
        end
      end
    end
  end

  initial begin
    logic                 r_rst, r_st, r_fl;
    logic [NISS-1:0]      r_en;
    logic [NISS*ADRW-1:0] r_adr;
    logic [NISS*CNTW-1:0] r_lat;
    logic [NSRC-1:0]      r_sv;
    logic [NSRC*ADRW-1:0] r_sa;

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    regwrite_en = '0; regwrite_adr = '0; regwrite_lat = '0;
    src_valid = '0; src_adr = '0;

    // Reset held with random issues present.
    step(1'b1, 1'b0, 1'b0, 2'b11, {3'd2, 3'd5}, {3'd4, 3'd6}, 2'b11, {3'd2, 3'd5});
    step(1'b1, 1'b0, 1'b0, 2'b11, {3'd1, 3'd0}, {3'd7, 3'd3}, 2'b11, {3'd1, 3'd0});
    idle(3'd2, 3'd5);

    // Countdown of r3 with latency 2.
    step(1'b0, 1'b0, 1'b0, 2'b01, {3'd0, 3'd3}, {3'd0, 3'd2}, 2'b11, {3'd0, 3'd3});
    repeat (3) idle(3'd3, 3'd0);

    // Same-register collision, then two distinct targets.
    step(1'b0, 1'b0, 1'b0, 2'b11, {3'd5, 3'd5}, {3'd3, 3'd1}, 2'b11, {3'd5, 3'd5});
    idle(3'd5, 3'd0);
    step(1'b0, 1'b0, 1'b0, 2'b11, {3'd6, 3'd2}, {3'd2, 3'd1}, 2'b11, {3'd6, 3'd2});
    repeat (4) idle(3'd6, 3'd2);

    // Stall holds counters and drops a pending issue.
    step(1'b0, 1'b0, 1'b0, 2'b01, {3'd0, 3'd1}, {3'd0, 3'd3}, 2'b11, {3'd4, 3'd1});
    repeat (4) step(1'b0, 1'b1, 1'b0, 2'b10, {3'd4, 3'd0}, {3'd2, 3'd0}, 2'b11, {3'd4, 3'd1});
    repeat (4) idle(3'd1, 3'd4);

    // Flush beats stall and an issue.
    step(1'b0, 1'b0, 1'b0, 2'b11, {3'd7, 3'd0}, {3'd1, 3'd2}, 2'b11, {3'd7, 3'd0});
    step(1'b0, 1'b1, 1'b1, 2'b01, {3'd0, 3'd0}, {3'd0, 3'd5}, 2'b11, {3'd7, 3'd0});
    idle(3'd0, 3'd7);

    // Saturation at zero, overwrite downward, full-range latency.
    repeat (10) idle(3'd0, 3'd4);
    step(1'b0, 1'b0, 1'b0, 2'b01, {3'd0, 3'd4}, {3'd0, 3'd5}, 2'b11, {3'd2, 3'd4});
    step(1'b0, 1'b0, 1'b0, 2'b10, {3'd4, 3'd0}, {3'd1, 3'd0}, 2'b11, {3'd2, 3'd4});
    repeat (2) idle(3'd4, 3'd2);
    step(1'b0, 1'b0, 1'b0, 2'b10, {3'd2, 3'd0}, {3'd7, 3'd0}, 2'b11, {3'd2, 3'd4});
    repeat (9) idle(3'd2, 3'd4);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 99) < 20);
      r_fl  = ($urandom_range(0, 99) < 4);
      r_en  = NISS'($urandom);
      r_adr = (NISS*ADRW)'($urandom);
      r_lat = (NISS*CNTW)'($urandom);
      r_sv  = NSRC'($urandom);
      r_sa  = (NSRC*ADRW)'($urandom);
      step(r_rst, r_st, r_fl, r_en, r_adr, r_lat, r_sv, r_sa);
    end
    idle(3'd0, 3'd1);

    @(negedge clk);
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
